// File: rtl/fb_port_arbiter_if.sv
// Bus bundle for fb_port_arbiter: timing inputs, writer handshake, RAM port and
// pixel output. The arbiter takes the slave side.
interface fb_port_arbiter_if #(
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 12,
    parameter int FIFO_DEPTH = 16
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic              video_active;
    logic [31:0]       scan_x;
    logic [31:0]       scan_y;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] pixel_out;
    logic              pixel_valid;
    logic [LVL_W-1:0]  fifo_level;
    logic              scan_oor;

    modport master (
        output video_active, scan_x, scan_y, wr_valid, wr_addr, wr_data, mem_rdata,
        input  wr_ready, mem_en, mem_we, mem_addr, mem_wdata, pixel_out, pixel_valid,
               fifo_level, scan_oor
    );

    modport slave (
        input  video_active, scan_x, scan_y, wr_valid, wr_addr, wr_data, mem_rdata,
        output wr_ready, mem_en, mem_we, mem_addr, mem_wdata, pixel_out, pixel_valid,
               fifo_level, scan_oor
    );
endinterface

// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer arbiter: scan-out reads own the RAM during active video,
// buffered writer traffic drains one entry per clock during blanking.
module fb_port_arbiter #(
    parameter int                H_ACTIVE   = 640,
    parameter int                V_ACTIVE   = 480,
    parameter int                ADDR_W     = 19,
    parameter int                DATA_W     = 12,
    parameter int                FIFO_DEPTH = 16,
    parameter logic [DATA_W-1:0] BORDER     = '0
) (
    input  logic             clock_in,
    input  logic             reset,
    fb_port_arbiter_if.slave bus
);
    localparam int               PTR_W   = $clog2(FIFO_DEPTH);
    localparam int               CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DRAIN = 2'd2} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_ent_t;

    state_t state_q, state_d;

    // Coordinate decode works on the low 16 bits of each coordinate only.
    logic [15:0]       sx, sy;
    logic              scan_oob;
    logic [ADDR_W-1:0] scan_addr;
    logic              unused_scan_hi;

    assign sx             = bus.scan_x[15:0];
    assign sy             = bus.scan_y[15:0];
    assign unused_scan_hi = ^{bus.scan_x[31:16], bus.scan_y[31:16]};
    assign scan_oob       = ({16'd0, sx} >= 32'(H_ACTIVE)) || ({16'd0, sy} >= 32'(V_ACTIVE));
    assign scan_addr      = ADDR_W'({16'd0, sy} * 32'(H_ACTIVE) + {16'd0, sx});

    wr_ent_t          fifo_q [FIFO_DEPTH];
    wr_ent_t          head;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_ready_q;
    logic             push, pop;

    assign push    = bus.wr_valid && wr_ready_q;
    assign head    = fifo_q[rd_ptr_q];
    assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    always_ff @(posedge clock_in) begin
        if (push) fifo_q[wr_ptr_q] <= {bus.wr_addr, bus.wr_data};
    end

    // wr_ready is a flop so it stays low through reset and rises on the first edge.
    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wr_ready_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q    <= count_d;
            wr_ready_q <= (count_d < DEPTH_C);
        end
    end

    logic              mem_en_d, mem_we_d, scan_oor_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d;
    logic              mem_en_q, mem_we_q, scan_oor_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.video_active)   state_d = SCAN;
                else if (count_q != '0) state_d = DRAIN;
            end
            SCAN: begin
                if (!bus.video_active)  state_d = (count_q != '0) ? DRAIN : IDLE;
            end
            DRAIN: begin
                if (bus.video_active)   state_d = SCAN;
                else if (count_q == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        pop         = 1'b0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        scan_oor_d  = scan_oor_q;
        unique case (state_d)
            SCAN: begin
                if (scan_oob) begin
                    scan_oor_d = 1'b1;
                end else begin
                    mem_en_d   = 1'b1;
                    mem_addr_d = scan_addr;
                end
            end
            DRAIN: begin
                pop         = 1'b1;
                mem_en_d    = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = head.addr;
                mem_wdata_d = head.data;
            end
            default: ;
        endcase
    end

    // Pixel pipeline: [0] command issued, [1] RAM data on mem_rdata, [2] pixel_out.
    logic [2:0]        vld_pipe_q;
    logic [1:0]        brd_pipe_q;
    logic [DATA_W-1:0] pixel_q;

    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            scan_oor_q  <= 1'b0;
            vld_pipe_q  <= '0;
            brd_pipe_q  <= '0;
            pixel_q     <= '0;
        end else begin
            state_q     <= state_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            scan_oor_q  <= scan_oor_d;
            vld_pipe_q  <= {vld_pipe_q[1:0], state_d == SCAN};
            brd_pipe_q  <= {brd_pipe_q[0], (state_d == SCAN) && scan_oob};
            pixel_q     <= vld_pipe_q[1] ? (brd_pipe_q[1] ? BORDER : bus.mem_rdata) : '0;
        end
    end

    assign bus.wr_ready    = wr_ready_q;
    assign bus.fifo_level  = count_q;
    assign bus.mem_en      = mem_en_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.scan_oor    = scan_oor_q;
    assign bus.pixel_valid = vld_pipe_q[2];
    assign bus.pixel_out   = pixel_q;
endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter: directed scenarios then random traffic, each cycle
// compared against a queue-based reference model and a behavioural RAM.
module tb_fb_port_arbiter;
    localparam int             H      = 640;
    localparam int             V      = 480;
    localparam int             AW     = 19;
    localparam int             DW     = 12;
    localparam int             D      = 16;
    localparam logic [DW-1:0]  BORDER = 12'hE07;

    typedef struct { int addr; logic [DW-1:0] data; } ent_t;
    typedef struct { int due;  logic [DW-1:0] v;    } pix_t;

    logic clock_in = 1'b0;
    logic reset    = 1'b0;
    always #5 clock_in = ~clock_in;

    fb_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(D)) bus ();

    fb_port_arbiter #(
        .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .DATA_W(DW),
        .FIFO_DEPTH(D), .BORDER(BORDER)
    ) dut (
        .clock_in (clock_in),
        .reset    (reset),
        .bus      (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Behavioural RAM (driven from DUT port) and the reference model's own RAM view.
    logic [DW-1:0] ram     [int];
    logic [DW-1:0] ref_mem [int];

    // Reference model state
    ent_t          mq[$];
    pix_t          pq[$];
    logic          e_en, e_we, e_oor, m_ready;
    int            e_addr;
    logic [DW-1:0] e_wdata;

    function automatic logic [DW-1:0] init_val(int a);
        return DW'(a * 37 + 11);
    endfunction

    function automatic logic [DW-1:0] ram_rd(int a);
        return ram.exists(a) ? ram[a] : init_val(a);
    endfunction

    function automatic logic [DW-1:0] ref_rd(int a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        pq.delete();
        e_en    = 1'b0;
        e_we    = 1'b0;
        e_oor   = 1'b0;
        m_ready = 1'b0;
        e_addr  = 0;
        e_wdata = '0;
    endtask

    // What the arbiter must do at the coming clock edge, from the current inputs.
    task automatic model_edge();
        logic accept;
        int   x, y;
        ent_t ent;
        cyc++;
        accept = bus.wr_valid && m_ready;
        if (bus.video_active) begin
            x    = int'(bus.scan_x & 32'h0000_FFFF);
            y    = int'(bus.scan_y & 32'h0000_FFFF);
            e_we = 1'b0;
            if (x >= H || y >= V) begin
                e_en  = 1'b0;
                e_oor = 1'b1;
                pq.push_back('{cyc + 2, BORDER});
            end else begin
                e_en   = 1'b1;
                e_addr = y * H + x;
                pq.push_back('{cyc + 2, ref_rd(y * H + x)});
            end
        end else if (mq.size() > 0) begin
            ent     = mq.pop_front();
            e_en    = 1'b1;
            e_we    = 1'b1;
            e_addr  = ent.addr;
            e_wdata = ent.data;
            ref_mem[ent.addr] = ent.data;
        end else begin
            e_en = 1'b0;
            e_we = 1'b0;
        end
        if (accept) mq.push_back('{int'(bus.wr_addr), bus.wr_data});
        m_ready = (mq.size() < D);
    endtask

    task automatic check_all();
        logic          ev;
        logic [DW-1:0] epx;
        ev  = 1'b0;
        epx = '0;
        if (pq.size() > 0 && pq[0].due == cyc) begin
            ev  = 1'b1;
            epx = pq[0].v;
            void'(pq.pop_front());
        end
        chk("mem_en",      32'(bus.mem_en),      32'(e_en));
        chk("mem_we",      32'(bus.mem_we),      32'(e_we));
        chk("mem_addr",    32'(bus.mem_addr),    e_addr);
        chk("mem_wdata",   32'(bus.mem_wdata),   32'(e_wdata));
        chk("wr_ready",    32'(bus.wr_ready),    32'(m_ready));
        chk("fifo_level",  32'(bus.fifo_level),  mq.size());
        chk("scan_oor",    32'(bus.scan_oor),    32'(e_oor));
        chk("pixel_valid", 32'(bus.pixel_valid), 32'(ev));
        chk("pixel_out",   32'(bus.pixel_out),   32'(epx));
    endtask

    // One clock: RAM model serves the command on the port, model predicts, then compare.
    task automatic tick();
        logic          do_rd;
        logic [DW-1:0] rd_v;
        do_rd = 1'b0;
        rd_v  = '0;
        if (bus.mem_en) begin
            if (bus.mem_we) ram[int'(bus.mem_addr)] = bus.mem_wdata;
            else begin
                do_rd = 1'b1;
                rd_v  = ram_rd(int'(bus.mem_addr));
            end
        end
        model_edge();
        @(posedge clock_in);
        #1;
        if (do_rd) bus.mem_rdata = rd_v;
        check_all();
    endtask

    task automatic idle_inputs();
        bus.video_active = 1'b0;
        bus.scan_x       = '0;
        bus.scan_y       = '0;
        bus.wr_valid     = 1'b0;
        bus.wr_addr      = '0;
        bus.wr_data      = '0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        logic va;
        idle_inputs();
        bus.mem_rdata = '0;
        model_reset();

        // Reset state, including while the clock runs
        #3;
        check_all();
        for (int i = 0; i < 2; i++) begin
            @(posedge clock_in);
            #1;
            check_all();
        end
        reset = 1'b1;
        tick();

        // Five buffered writes during blanking
        for (int i = 0; i < 5; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_addr  = AW'(i);
            bus.wr_data  = DW'(12'h101 + i);
            tick();
        end
        idle_inputs();
        ticks(4);

        // Single scan position (2,3) -> address 1283
        bus.video_active = 1'b1;
        bus.scan_x       = 32'd3;
        bus.scan_y       = 32'd2;
        ticks(3);
        idle_inputs();
        ticks(3);

        // Scan a few written addresses to confirm write ordering reached RAM
        bus.video_active = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.scan_x = 32'(i);
            tick();
        end
        idle_inputs();
        ticks(3);

        // Writer streams through 20 active cycles, then into blanking
        bus.video_active = 1'b1;
        bus.wr_valid     = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.scan_x  = $urandom_range(0, H - 1);
            bus.scan_y  = $urandom_range(0, 3);
            bus.wr_addr = AW'($urandom_range(0, 2559));
            bus.wr_data = DW'($urandom);
            tick();
        end
        bus.video_active = 1'b0;
        for (int i = 0; i < 12; i++) begin
            bus.wr_addr = AW'($urandom_range(0, 2559));
            bus.wr_data = DW'($urandom);
            tick();
        end
        idle_inputs();
        ticks(20);

        // Out-of-range columns, truncated coordinates, sticky scan_oor
        bus.video_active = 1'b1;
        bus.scan_x       = 32'd640;
        bus.scan_y       = 32'd0;
        ticks(2);
        bus.scan_x = 32'h0001_0005;
        bus.scan_y = 32'hFFFF_0001;
        tick();
        bus.scan_x = 32'd10;
        bus.scan_y = 32'd480;
        tick();
        bus.scan_y = 32'd1;
        tick();
        idle_inputs();
        ticks(4);

        // Reset while draining with eight entries left
        bus.video_active = 1'b1;
        bus.wr_valid     = 1'b1;
        for (int i = 0; i < 18; i++) begin
            bus.wr_addr = AW'($urandom_range(0, 2559));
            bus.wr_data = DW'($urandom);
            tick();
        end
        idle_inputs();
        ticks(8);
        chk("level_pre_reset", 32'(bus.fifo_level), 32'd8);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_all();
        for (int i = 0; i < 2; i++) begin
            @(posedge clock_in);
            #1;
            check_all();
        end
        reset = 1'b1;
        ticks(6);

        // Random traffic
        va = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) va = ~va;
            bus.video_active = va;
            bus.scan_x = ($urandom_range(0, 15) == 0) ? 32'($urandom_range(640, 700))
                                                     : 32'($urandom_range(0, H - 1));
            if ($urandom_range(0, 31) == 0) bus.scan_x = bus.scan_x | 32'h0003_0000;
            bus.scan_y = ($urandom_range(0, 31) == 0) ? 32'($urandom_range(480, 500))
                                                     : 32'($urandom_range(0, 3));
            bus.wr_valid = ($urandom_range(0, 2) != 0);
            bus.wr_addr  = AW'($urandom_range(0, 2559));
            bus.wr_data  = DW'($urandom);
            tick();
        end
        idle_inputs();
        ticks(24);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
- Shares one single-port pixel RAM between two users:
  - the display scan-out, driven by the video timing controller's video_active and active-area coordinates;
  - a pixel writer, such as the draw engine or CPU bridge.
- Scan-out has absolute priority during active video.
- Writer traffic is buffered in an internal FIFO and drained into RAM only during blanking.
- Sits between the timing generator, the frame-buffer RAM and the colour output stage.

Parameters:
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines per frame.
- ADDR_W, 19, RAM address width. Must satisfy H_ACTIVE*V_ACTIVE <= 2^ADDR_W.
- DATA_W, 12, pixel width (RGB444).
- FIFO_DEPTH, 16, write FIFO entries. Power of two, >= 2.
- BORDER, 12'h000, pixel value output for out-of-range coordinates.

Ports:
- clock_in, in, 1, pixel clock.
- reset, in, 1, asynchronous, active-low.
- video_active, in, 1, timing controller active-video flag.
- scan_x, in, 32, active-area column of the current pixel.
- scan_y, in, 32, active-area row of the current pixel.
- wr_valid, in, 1, writer request.
- wr_ready, out, 1, FIFO can accept an entry.
- wr_addr, in, ADDR_W, writer RAM address.
- wr_data, in, DATA_W, writer pixel.
- mem_en, out, 1, RAM access strobe.
- mem_we, out, 1, RAM write enable.
- mem_addr, out, ADDR_W, RAM address.
- mem_wdata, out, DATA_W, RAM write data.
- mem_rdata, in, DATA_W, RAM read data, valid 1 cycle after a read strobe.
- pixel_out, out, DATA_W, pixel to colour stage.
- pixel_valid, out, 1, pixel_out is valid.
- fifo_level, out, clog2(FIFO_DEPTH)+1, current FIFO occupancy.
- scan_oor, out, 1, out-of-range coordinate seen (sticky).

Behaviour:
- Reset (reset low, asynchronous): all outputs 0, state IDLE, FIFO pointers and count 0, FIFO contents discarded.
  - wr_ready rises on the first clock edge after reset deasserts.
  - Reset mid-operation: any in-flight read result is dropped; no pixel_valid pulse follows.
- FSM, evaluated every clock edge. States: IDLE, SCAN, DRAIN.
  - Any state, video_active=1 -> SCAN.
  - video_active=0 and FIFO non-empty -> DRAIN.
  - video_active=0 and FIFO empty -> IDLE.
  - video_active is sampled directly; there is no hysteresis.
- SCAN:
  - Issues mem_en=1, mem_we=0, mem_addr = scan_y*H_ACTIVE + scan_x, truncated to ADDR_W.
  - Only the low 16 bits of scan_x and scan_y are used.
  - The FIFO is never popped in this state.
- Out-of-range coordinates (scan_x >= H_ACTIVE or scan_y >= V_ACTIVE) while video_active=1:
  - mem_en=0 that cycle;
  - the pixel is substituted with BORDER;
  - scan_oor is set and stays set until reset.
- Read latency: 2 cycles.
  - Cycle N: the video_active=1 sample.
  - Cycle N+1: mem_rdata arrives.
  - Cycle N+2: pixel_out registered, pixel_valid=1.
  - A BORDER substitution follows the same 2-cycle pipeline.
  - When pixel_valid=0, pixel_out=0.
- DRAIN: each cycle pops one FIFO entry and issues mem_en=1, mem_we=1 with the entry's address and data. This gives a sustained drain rate of 1 write per clock.
- IDLE: mem_en=0, mem_we=0; mem_addr and mem_wdata hold their last value.
- Write handshake:
  - wr_ready = (count < FIFO_DEPTH), driven from the registered count.
  - An entry is pushed when wr_valid and wr_ready are both 1 on a clock edge.
  - Pushes are accepted in every state, including SCAN.
- Simultaneous push and pop: count is unchanged; both pointers advance.
  - When full, a same-cycle pop does not raise wr_ready until the next cycle; no push occurs that cycle.
- Ordering:
  - FIFO is strict first-in first-out.
  - A write to an address takes effect before any later write to the same address.
  - A scan read during the same frame may return the pre-write value; that is accepted.
- Wrap-around: pointers are clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Full/empty are decided by count, not by pointer comparison.
- The RAM port carries at most one access per cycle; read and write are never asserted together.

Test Plan:
- Push 5 writes (addr 0..4, data 12'h101..12'h105) with video_active=0:
  - the 5 pushes are accepted;
  - 5 consecutive mem_we=1 cycles follow, in order;
  - fifo_level returns to 0, then the state returns to IDLE.
- Hold video_active=1 with scan_y=2, scan_x=3, H_ACTIVE=640:
  - mem_addr=1283, mem_we=0;
  - pixel_valid rises exactly 2 cycles after video_active;
  - pixel_out equals the RAM contents at 1283.
- Hold video_active=1 for 20 cycles while wr_valid=1 continuously:
  - 16 entries are accepted, then wr_ready=0 and fifo_level=16;
  - no mem_we=1 occurs during video_active;
  - draining begins on the first blanking cycle, and wr_ready=1 the cycle after the first pop.
- Full FIFO, blanking, wr_valid=1 held: fifo_level holds at 15/16 alternating as pops and pushes overlap; no entry is lost or duplicated (checked by scoreboard).
- Scan with scan_x=640 while video_active=1: mem_en=0, pixel_out=BORDER after 2 cycles, scan_oor=1 and sticky.
- Assert reset low mid-drain with fifo_level=8:
  - all outputs are 0 immediately;
  - after release, fifo_level=0 and no stale writes are issued.
